// File: rtl/ram_arb_pkg.sv
// Shared types for the MC14500B RAM arbiter.
// Optional macro: RAM_ARBITER_FIXED_PRIO_EN (fixed priority instead of round-robin).
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } ram_arb_state_t;

    localparam int RAM_ARB_ACCESS_CYCLES = 4;

endpackage

// File: rtl/rr_pick.sv
// One-hot grant picker: round-robin from a start index, or a plain
// priority encoder when RAM_ARBITER_FIXED_PRIO_EN is defined.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
`ifndef RAM_ARBITER_FIXED_PRIO_EN
    input  logic [PW-1:0] start,
`endif
    output logic [N-1:0]  grant
);

    logic [N-1:0] lo;
    logic         found_lo;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
    logic [N-1:0] hi;
    logic         found_hi;
`endif

    // hi: first requester at or after start; lo: first overall (the wrap case)
    always_comb begin
        lo       = '0;
        found_lo = 1'b0;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
        hi       = '0;
        found_hi = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found_lo) begin
                lo[i]    = 1'b1;
                found_lo = 1'b1;
            end
`ifndef RAM_ARBITER_FIXED_PRIO_EN
            if (req[i] && !found_hi && (i >= int'(start))) begin
                hi[i]    = 1'b1;
                found_hi = 1'b1;
            end
`endif
        end
    end

`ifndef RAM_ARBITER_FIXED_PRIO_EN
    assign grant = found_hi ? hi : lo;
`else
    assign grant = lo;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates NUM_REQ requesters onto one async-read, level-write RAM.
// Optional macro: RAM_ARBITER_FIXED_PRIO_EN (fixed priority, no pointer).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          ram_write,
    output logic [ADDR_WIDTH-1:0]         ram_address,
    output logic [DATA_WIDTH-1:0]         ram_data_in,
    input  logic [DATA_WIDTH-1:0]         ram_data_out
);

    ram_arb_state_t state, next_state;

    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    win_q;
    logic                  wr_q;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

`ifndef RAM_ARBITER_FIXED_PRIO_EN
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] sel_idx;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req   (req),
        .start (ptr),
        .grant (grant)
    );

    assign ptr_next = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
`else
    rr_pick #(
        .N  (NUM_REQ),
        .PW (1)
    ) u_pick (
        .req   (req),
        .grant (grant)
    );
`endif

    always_comb begin
        sel_wr   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
        sel_idx  = '0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_wr   = req_write[i];
                sel_addr = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifndef RAM_ARBITER_FIXED_PRIO_EN
                sel_idx  = PW'(i);
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (|req) next_state = SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  next_state = HOLD;
            HOLD:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they line up with the state
    always_ff @(posedge clock) begin
        if (reset) begin
            ack         <= '0;
            rd_data     <= '0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            win_q       <= '0;
            wr_q        <= 1'b0;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
            ptr         <= '0;
`endif
        end else begin
            ram_write <= (next_state == STROBE) && wr_q;
            ack       <= (next_state == HOLD) ? win_q : '0;
            if (state == IDLE && |req) begin
                win_q       <= grant;
                wr_q        <= sel_wr;
                ram_address <= sel_addr;
                ram_data_in <= sel_data;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
                ptr         <= ptr_next;
`endif
            end
            if (state == STROBE && !wr_q) rd_data <= ram_data_out;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: two-requester and three-requester
// instances, each with a behavioural RAM behind it.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    typedef struct {
        int         idx;
        bit         rd;
        logic [7:0] d;
    } exp_t;

`ifdef RAM_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mem_clr = 1'b1;

    logic [1:0]  req2 = '0, wr2 = '0, ack2;
    logic [15:0] addr2 = '0, data2 = '0;
    logic [7:0]  rd2, rama2, ramdi2, ramdo2;
    logic        ramw2;

    logic [2:0]  req3 = '0, wr3 = '0, ack3;
    logic [23:0] addr3 = '0, data3 = '0;
    logic [7:0]  rd3, rama3, ramdi3, ramdo3;
    logic        ramw3;

    logic [7:0] mem2 [256];
    logic [7:0] mem3 [256];
    bit   [7:0] sh2 [256];
    bit   [7:0] sh3 [256];

    exp_t q2[$], q3[$];
    exp_t e2, e3;
    int   n_cmp = 0, n_bad = 0;
    int   wp2 = 0, wp3 = 0;
    logic prev_w2 = 1'b0, prev_w3 = 1'b0;

    always #5 clock = ~clock;

    ram_arbiter #(.NUM_REQ(2), .DATA_WIDTH(8), .ADDR_WIDTH(8)) u2 (
        .clock(clock), .reset(reset), .req(req2), .req_write(wr2),
        .req_address(addr2), .req_data(data2), .ack(ack2), .rd_data(rd2),
        .ram_write(ramw2), .ram_address(rama2), .ram_data_in(ramdi2),
        .ram_data_out(ramdo2)
    );

    ram_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .ADDR_WIDTH(8)) u3 (
        .clock(clock), .reset(reset), .req(req3), .req_write(wr3),
        .req_address(addr3), .req_data(data3), .ack(ack3), .rd_data(rd3),
        .ram_write(ramw3), .ram_address(rama3), .ram_data_in(ramdi3),
        .ram_data_out(ramdo3)
    );

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem2[i] <= '0;
                mem3[i] <= '0;
            end
        end else begin
            if (ramw2) mem2[rama2] <= ramdi2;
            if (ramw3) mem3[rama3] <= ramdi3;
        end
    end
    assign ramdo2 = mem2[rama2];
    assign ramdo3 = mem3[rama3];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (ramw2) begin
            wp2++;
            chk("ramw2_consecutive", 32'(prev_w2), 32'(0));
        end
        prev_w2 = ramw2;
        if (ack2 != 0) begin
            if (q2.size() == 0) chk("ack2_unexpected", 32'(ack2), 32'(0));
            else begin
                e2 = q2.pop_front();
                chk("ack2", 32'(ack2), 32'(1) << e2.idx);
                if (e2.rd) chk("rd2", 32'(rd2), 32'(e2.d));
            end
        end
    end

    always @(negedge clock) begin
        if (ramw3) begin
            wp3++;
            chk("ramw3_consecutive", 32'(prev_w3), 32'(0));
        end
        prev_w3 = ramw3;
        if (ack3 != 0) begin
            if (q3.size() == 0) chk("ack3_unexpected", 32'(ack3), 32'(0));
            else begin
                e3 = q3.pop_front();
                chk("ack3", 32'(ack3), 32'(1) << e3.idx);
                if (e3.rd) chk("rd3", 32'(rd3), 32'(e3.d));
            end
        end
    end

    task automatic set2(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
        wr2[i] = w;
        addr2[i*8 +: 8] = a;
        data2[i*8 +: 8] = d;
    endtask

    task automatic set3(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
        wr3[i] = w;
        addr3[i*8 +: 8] = a;
        data3[i*8 +: 8] = d;
    endtask

    task automatic exp2(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.idx = i;
        e.rd  = !w;
        if (w) begin
            sh2[a] = d;
            e.d = d;
        end else e.d = sh2[a];
        q2.push_back(e);
    endtask

    task automatic exp3(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.idx = i;
        e.rd  = !w;
        if (w) begin
            sh3[a] = d;
            e.d = d;
        end else e.d = sh3[a];
        q3.push_back(e);
    endtask

    // Each requester holds req until its own ack, then drops it
    task automatic wait2();
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) if (req2[i] && ack2[i]) req2[i] = 1'b0;
            if (req2 == 0) break;
        end
        chk("wait2_timeout", 32'(req2), 32'(0));
        req2 = '0;
    endtask

    task automatic wait3();
        for (int t = 0; t < 80; t++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) if (req3[i] && ack3[i]) req3[i] = 1'b0;
            if (req3 == 0) break;
        end
        chk("wait3_timeout", 32'(req3), 32'(0));
        req3 = '0;
    endtask

    task automatic run2(input logic [1:0] m);
        @(posedge clock); #1;
        req2 = m;
        wait2();
    endtask

    task automatic run3(input logic [2:0] m);
        @(posedge clock); #1;
        req3 = m;
        wait3();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         w0, wc, cnt, cyc, last;
        int         ord [3];
        logic [7:0] dat [3];

        repeat (3) @(posedge clock);
        #1;
        reset   = 1'b0;
        mem_clr = 1'b0;

        @(negedge clock);
        chk("rst_ack", 32'(ack2), 32'(0));
        chk("rst_ram_write", 32'(ramw2), 32'(0));
        chk("rst_ram_address", 32'(rama2), 32'(0));
        chk("rst_ram_data_in", 32'(ramdi2), 32'(0));
        chk("rst_rd_data", 32'(rd2), 32'(0));

        // 1: single write, cycle-by-cycle RAM pins
        set2(0, 1'b1, 8'h10, 8'hA5);
        exp2(0, 1'b1, 8'h10, 8'hA5);
        @(posedge clock); #1;
        req2 = 2'b01;
        @(negedge clock);
        chk("t1_idle_ram_write", 32'(ramw2), 32'(0));
        wc = 0;
        for (int c = 1; c < RAM_ARB_ACCESS_CYCLES; c++) begin
            @(negedge clock);
            if (ramw2) wc++;
            chk("t1_ram_write", 32'(ramw2), (c == 2) ? 32'(1) : 32'(0));
            chk("t1_ram_address", 32'(rama2), 32'h10);
            chk("t1_ram_data_in", 32'(ramdi2), 32'hA5);
        end
        chk("t1_ack_after_3", 32'(ack2), 32'(1));
        req2 = '0;
        @(negedge clock);
        chk("t1_ram_write_after", 32'(ramw2), 32'(0));
        chk("t1_ack_one_cycle", 32'(ack2), 32'(0));
        chk("t1_strobe_count", 32'(wc), 32'(1));

        // 2: read back, no strobe
        @(posedge clock); #1;
        w0 = wp2;
        set2(0, 1'b0, 8'h10, 8'h00);
        exp2(0, 1'b0, 8'h10, 8'h00);
        run2(2'b01);
        @(posedge clock); #1;
        chk("t2_no_strobe", 32'(wp2 - w0), 32'(0));

        // requester 1 writes so the pointer returns to 0
        set2(1, 1'b1, 8'h20, 8'h3C);
        exp2(1, 1'b1, 8'h20, 8'h3C);
        run2(2'b10);

        // 3: both held for 8 accesses
        set2(0, 1'b0, 8'h10, 8'h00);
        set2(1, 1'b0, 8'h20, 8'h00);
        for (int k = 0; k < 8; k++) begin
            if (FIXED || (k % 2 == 0)) exp2(0, 1'b0, 8'h10, 8'h00);
            else exp2(1, 1'b0, 8'h20, 8'h00);
        end
        @(posedge clock); #1;
        req2 = 2'b11;
        cnt  = 0;
        cyc  = 0;
        last = -1;
        for (int t = 0; t < 80 && cnt < 8; t++) begin
            @(negedge clock);
            cyc++;
            if (ack2 != 0) begin
                if (last >= 0) chk("t3_spacing", 32'(cyc - last), 32'(RAM_ARB_ACCESS_CYCLES));
                last = cyc;
                cnt++;
                if (cnt == 8) req2 = '0;
            end
        end
        req2 = '0;
        chk("t3_count", 32'(cnt), 32'(8));

        // 4: one-cycle req[1] pulse during requester 0's access
        set2(0, 1'b1, 8'h30, 8'h77);
        exp2(0, 1'b1, 8'h30, 8'h77);
        set2(1, 1'b1, 8'h31, 8'hEE);
        @(posedge clock); #1;
        w0 = wp2;
        req2 = 2'b01;
        @(posedge clock); #1;
        req2[1] = 1'b1;
        @(posedge clock); #1;
        req2[1] = 1'b0;
        wait2();
        @(posedge clock); #1;
        chk("t4_strobes", 32'(wp2 - w0), 32'(1));
        set2(1, 1'b0, 8'h31, 8'h00);
        exp2(1, 1'b0, 8'h31, 8'h00);
        run2(2'b10);

        // 5: reset during STROBE of a write
        set2(0, 1'b1, 8'h40, 8'h99);
        @(posedge clock); #1;
        req2 = 2'b01;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("t5_in_strobe", 32'(ramw2), 32'(1));
        reset = 1'b1;
        @(negedge clock);
        chk("t5_ram_write_cleared", 32'(ramw2), 32'(0));
        chk("t5_no_ack", 32'(ack2), 32'(0));
        reset = 1'b0;
        req2  = '0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            chk("t5_no_late_ack", 32'(ack2), 32'(0));
        end
        set2(0, 1'b0, 8'h10, 8'h00);
        set2(1, 1'b0, 8'h20, 8'h00);
        exp2(0, 1'b0, 8'h10, 8'h00);
        exp2(1, 1'b0, 8'h20, 8'h00);
        run2(2'b11);

        // 6: three requesters, pointer parked at 2
        set3(1, 1'b1, 8'h05, 8'h51);
        exp3(1, 1'b1, 8'h05, 8'h51);
        run3(3'b010);
        if (FIXED) ord = '{0, 1, 2};
        else       ord = '{2, 0, 1};
        dat = '{8'hA0, 8'hB1, 8'hC2};
        for (int i = 0; i < 3; i++) set3(i, 1'b1, 8'(i), dat[i]);
        for (int k = 0; k < 3; k++) exp3(ord[k], 1'b1, 8'(ord[k]), dat[ord[k]]);
        run3(3'b111);
        for (int i = 0; i < 3; i++) set3(i, 1'b0, 8'(i), 8'h00);
        for (int k = 0; k < 3; k++) exp3(ord[k], 1'b0, 8'(ord[k]), 8'h00);
        run3(3'b111);
        set3(0, 1'b0, 8'h05, 8'h00);
        exp3(0, 1'b0, 8'h05, 8'h00);
        run3(3'b001);

        repeat (6) @(posedge clock);
        #1;
        chk("q2_drained", 32'(q2.size()), 32'(0));
        chk("q3_drained", 32'(q3.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
